mdu_iterative: RTL and testbench
================================

// Module: mdu_iterative
// PURPOSE
//  RV32M multiply/divide unit for the execute stage. Reads rs1/rs2 operands from regfile.
//  Produces one write-back (rd, data) toward the regfile write port after an iterative computation.
//  Uses a valid/ready handshake on both sides so the core can stall while a result is pending.
// PARAMETERS
//  XLEN  32  operand/result width; must be even and >= 8
// PORTS
//  i_clk         in   1     clock, all state updates on rising edge
//  i_reset       in   1     asynchronous, active-high reset
//  i_flush       in   1     synchronous abort of any in-flight op
//  i_valid       in   1     request valid
//  o_ready       out  1     unit idle, request accepted when i_valid & o_ready
//  i_op          in   3     funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  i_rs1_data    in   XLEN  operand A (dividend / multiplicand)
//  i_rs2_data    in   XLEN  operand B (divisor / multiplier)
//  i_rd_addr     in   5     destination register
//  o_valid       out  1     result valid; holds until i_ready
//  i_ready       in   1     consumer takes result when o_valid & i_ready
//  o_rd_addr     out  5     captured destination
//  o_rd_data     out  XLEN  result
//  o_rd_wren     out  1     equals o_valid & i_ready; drives regfile write enable
// BEHAVIOUR
//  Reset: state IDLE; o_ready=1, o_valid=0, o_rd_addr=0, o_rd_data=0, o_rd_wren=0.
//  FSM states and transitions:
//  - IDLE: o_ready=1. On accept, latch op, rd_addr, |A| and |B| plus the result sign.
//    Signed ops take magnitudes: MULH/DIV/REM treat both operands as signed; MULHSU only A; others none.
//    Div-by-zero or signed overflow -> DONE. Else -> CALC with cnt=XLEN-1.
//  - CALC: one radix-2 step per cycle.
//    Multiply: shift-add into a 2*XLEN accumulator.
//    Divide: restoring subtract, quotient bit shifted in, remainder kept XLEN+1 bits.
//    cnt decrements; at cnt==0 -> FIX.
//  - FIX: conditionally negate (two's complement).
//    MUL/MULH*: negate the 2*XLEN product if sign set.
//    DIV: quotient negated if signs of A and B differ.
//    REM: remainder takes the sign of A.
//    Select the result: MUL = low XLEN; MULH* = high XLEN; DIV* = quotient; REM* = remainder.
//    Register o_rd_data. -> DONE.
//  - DONE: o_valid=1, o_rd_data/o_rd_addr stable. On i_ready -> IDLE.
//    No new accept in the same cycle (o_ready=0 in DONE).
//  Latency: normal op is accept edge + XLEN+2 edges to o_valid (34 @ XLEN=32). Special cases: 1 edge.
//  Special results:
//  - Div by zero: DIV/DIVU = all ones; REM/REMU = A.
//  - Overflow (DIV, A=-2^(XLEN-1), B=-1): quotient = A, REM = 0.
//  - MULHU/MULHSU/MULH: full 2*XLEN product, no truncation before the sign fix.
//  i_flush:
//  - Any state -> IDLE next edge. o_valid drops. A pending result is discarded, no o_rd_wren.
//  - Flush with i_valid in IDLE: flush wins, request not accepted.
//  Async reset mid-CALC aborts immediately; outputs return to reset values.
//  o_rd_addr==0 is computed and written normally; the regfile itself discards x0 writes.
//  Operands are sampled only at accept; later changes on i_rs*_data are ignored.
// STRUCTURE
//  mdu_pkg:
//  - typedef enum logic[2:0] mdu_op_e (funct3 encodings above)
//  - typedef enum state_e {IDLE,CALC,FIX,DONE}
//  - helper functions is_signed_a/is_signed_b/is_div
//  Sub-module mdu_iter_step (combinational): one shift-add or restoring-subtract step.
//  The FSM, counter, latching and sign fix stay in mdu_iterative.
// TESTING
//  1. MUL 7 x -3 -> o_rd_data=0xFFFFFFEB; o_valid exactly 34 cycles after accept.
//  2. MULH 0x80000000 x 0x80000000 -> 0x40000000.
//     MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
//     MULHSU -1 x 2 -> 0xFFFFFFFF.
//  3. DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
//  4. DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5.
//     DIV 0x80000000/-1 -> 0x80000000; REM -> 0.
//     o_valid 1 edge after accept.
//  5. Hold i_ready=0 for 5 cycles in DONE -> data/addr stable, o_ready=0, o_rd_wren=0.
//     Then i_ready=1 -> one o_rd_wren pulse, then IDLE.
//  6. i_flush at CALC cycle 10 -> no o_valid; next op DIVU 9/3 -> 3.
//     Assert i_reset mid-CALC -> o_ready=1, o_valid=0 immediately.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types and operation classifiers for the iterative multiply/divide unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_e;

  function automatic logic is_signed_a(input mdu_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_b(input mdu_op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_div(input mdu_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_rem(input mdu_op_e op);
    return op inside {OP_REM, OP_REMU};
  endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One radix-2 iteration on unsigned magnitudes: shift-add multiply or restoring divide.
// Multiply: hi/lo form the 2*XLEN accumulator, lo starts as the multiplier.
// Divide:   hi is the partial remainder, lo starts as the dividend and collects quotient bits.
module mdu_iter_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN:0]   hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] opnd,
  output logic [XLEN:0]   hi_nxt,
  output logic [XLEN-1:0] lo_nxt
);

  logic [XLEN:0]   sum;
  logic [XLEN+1:0] rem_sh;
  logic [XLEN+1:0] diff;

  // Single combinational step; the divide path needs one extra bit to see the borrow.
  always_comb begin
    sum    = hi + {1'b0, (lo[0] ? opnd : '0)};
    rem_sh = {hi, lo[XLEN-1]};
    diff   = rem_sh - {2'b00, opnd};
    hi_nxt = '0;
    lo_nxt = '0;
    if (is_div) begin
      hi_nxt = diff[XLEN+1] ? rem_sh[XLEN:0] : diff[XLEN:0];
      lo_nxt = {lo[XLEN-2:0], ~diff[XLEN+1]};
    end else begin
      hi_nxt = {1'b0, sum[XLEN:1]};
      lo_nxt = {sum[0], lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mdu_iterative.sv
// RV32M multiply/divide unit: accepts one op, iterates XLEN steps, sign-fixes, writes back.
//
//  state | meaning
//  IDLE  | o_ready=1, waiting for a request
//  CALC  | one shift-add / restoring-subtract step per cycle, cnt counts down
//  FIX   | two's complement fix-up and result selection into o_rd_data
//  DONE  | o_valid=1, holding result until the consumer takes it
module mdu_iterative
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [4:0]      i_rd_addr,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [4:0]      o_rd_addr,
  output logic [XLEN-1:0] o_rd_data,
  output logic            o_rd_wren
);

  localparam int CW = $clog2(XLEN);

  state_e            state_q, state_nxt;
  mdu_op_e           op_in, op_q;
  logic [CW-1:0]     cnt_q;
  logic [XLEN:0]     hi_q, hi_nxt;
  logic [XLEN-1:0]   lo_q, lo_nxt;
  logic [XLEN-1:0]   opnd_q;
  logic              neg_q;

  logic              accept, div_zero, ovf, special;
  logic              sa, sb, neg_in;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_result;

  assign op_in     = mdu_op_e'(i_op);
  assign o_ready   = (state_q == IDLE);
  assign o_valid   = (state_q == DONE);
  // A flush in DONE discards the result, so it must also suppress the write.
  assign o_rd_wren = o_valid & i_ready & ~i_flush;
  assign accept    = i_valid & o_ready & ~i_flush;

  // Operand magnitudes, result sign and the cases that skip iteration.
  always_comb begin
    sa       = is_signed_a(op_in) & i_rs1_data[XLEN-1];
    sb       = is_signed_b(op_in) & i_rs2_data[XLEN-1];
    a_mag    = sa ? -i_rs1_data : i_rs1_data;
    b_mag    = sb ? -i_rs2_data : i_rs2_data;
    neg_in   = is_rem(op_in) ? sa : (sa ^ sb);
    div_zero = is_div(op_in) && (i_rs2_data == '0);
    ovf      = (op_in inside {OP_DIV, OP_REM}) &&
               (i_rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (&i_rs2_data);
    special  = div_zero | ovf;
  end

  mdu_iter_step #(.XLEN(XLEN)) u_step (
    .is_div (is_div(op_q)),
    .hi     (hi_q),
    .lo     (lo_q),
    .opnd   (opnd_q),
    .hi_nxt (hi_nxt),
    .lo_nxt (lo_nxt)
  );

  // Sign fix on the full-width product before selecting the half, then pick the result.
  always_comb begin
    prod     = {hi_q[XLEN-1:0], lo_q};
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = neg_q ? -lo_q : lo_q;
    rem_fix  = neg_q ? -hi_q[XLEN-1:0] : hi_q[XLEN-1:0];
    fix_result = quo_fix;
    case (op_q)
      OP_MUL:                       fix_result = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod_fix[2*XLEN-1:XLEN];
      OP_REM, OP_REMU:              fix_result = rem_fix;
      default:                      fix_result = quo_fix;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_nxt;
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE: if (accept) state_nxt = special ? DONE : CALC;
      CALC: if (cnt_q == '0) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: if (i_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (i_flush) state_nxt = IDLE;
  end

  // Operand capture, iteration registers and the registered result.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      op_q      <= OP_MUL;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      neg_q     <= 1'b0;
      o_rd_addr <= '0;
      o_rd_data <= '0;
    end else if (accept) begin
      op_q      <= op_in;
      o_rd_addr <= i_rd_addr;
      neg_q     <= neg_in;
      cnt_q     <= CW'(XLEN-1);
      hi_q      <= '0;
      lo_q      <= is_div(op_in) ? a_mag : b_mag;
      opnd_q    <= is_div(op_in) ? b_mag : a_mag;
      if (div_zero)
        o_rd_data <= is_rem(op_in) ? i_rs1_data : '1;
      else if (ovf)
        o_rd_data <= is_rem(op_in) ? '0 : i_rs1_data;
    end else if (state_q == CALC) begin
      hi_q  <= hi_nxt;
      lo_q  <= lo_nxt;
      cnt_q <= cnt_q - 1'b1;
    end else if (state_q == FIX && !i_flush) begin
      o_rd_data <= fix_result;
    end
  end

endmodule

// File: tb/tb_mdu_iterative.sv
// Scoreboard bench for mdu_iterative: driver pushes reference results, monitor pops on write-back.
module tb_mdu_iterative;

  localparam int XLEN = 32;

  logic        i_clk = 1'b0;
  logic        i_reset, i_flush, i_valid, i_ready;
  logic [2:0]  i_op;
  logic [31:0] i_rs1_data, i_rs2_data;
  logic [4:0]  i_rd_addr;
  logic        o_ready, o_valid, o_rd_wren;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd_data;

  int checks = 0;
  int errors = 0;
  int wren_count = 0;
  logic [31:0] exp_data_q[$];
  logic [4:0]  exp_addr_q[$];

  mdu_iterative #(.XLEN(XLEN)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_flush    (i_flush),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_op       (i_op),
    .i_rs1_data (i_rs1_data),
    .i_rs2_data (i_rs2_data),
    .i_rd_addr  (i_rd_addr),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_rd_addr  (o_rd_addr),
    .o_rd_data  (o_rd_data),
    .o_rd_wren  (o_rd_wren)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model straight from the RV32M definitions using wide arithmetic.
  function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p, ua64, ub64;
    int          ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    ua64 = {32'b0, a};
    ub64 = {32'b0, b};
    ia = $signed(a);
    ib = $signed(b);
    case (op)
      3'd0: begin p = sa * sb;     return p[31:0];  end
      3'd1: begin p = sa * sb;     return p[63:32]; end
      3'd2: begin p = sa * ub;     return p[63:32]; end
      3'd3: begin p = ua64 * ub64; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Monitor: every write-back must match the oldest outstanding expectation.
  always @(negedge i_clk) begin
    if (!i_reset && o_rd_wren) begin
      logic [31:0] ed;
      logic [4:0]  ea;
      wren_count++;
      if (exp_data_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got data 0x%08h addr %0d, required no write",
                 o_rd_data, o_rd_addr);
      end else begin
        ed = exp_data_q.pop_front();
        ea = exp_addr_q.pop_front();
        check("wb_data", o_rd_data, ed);
        check("wb_addr", {27'b0, o_rd_addr}, {27'b0, ea});
      end
    end
  end

  // Issue one request, record its expectation and check the accept-to-valid latency.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    int t;
    int n;
    bit special;
    @(posedge i_clk); #1;
    t = 0;
    while (!o_ready && t < 200) begin
      @(posedge i_clk); #1;
      t++;
    end
    if (!o_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: o_ready 0 required 1");
      return;
    end
    i_valid = 1'b1; i_op = op; i_rs1_data = a; i_rs2_data = b; i_rd_addr = rd;
    @(posedge i_clk);
    exp_data_q.push_back(ref_mdu(op, a, b));
    exp_addr_q.push_back(rd);
    #1;
    i_valid = 1'b0;
    i_rs1_data = $urandom; i_rs2_data = $urandom;
    i_rd_addr = 5'($urandom); i_op = 3'($urandom);
    special = op[2] && (b == 0 ||
              ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    n = 1;
    @(negedge i_clk);
    while (!o_valid && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    check("latency", 32'(n), special ? 32'd1 : 32'd34);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int wc;
    int vcnt;
    i_reset = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    i_op = 3'd0; i_rs1_data = '0; i_rs2_data = '0; i_rd_addr = '0;
    #12;
    check("rst_ready", {31'b0, o_ready}, 32'd1);
    check("rst_valid", {31'b0, o_valid}, 32'd0);
    check("rst_wren",  {31'b0, o_rd_wren}, 32'd0);
    check("rst_data",  o_rd_data, 32'd0);
    check("rst_addr",  {27'b0, o_rd_addr}, 32'd0);
    @(negedge i_clk);
    i_reset = 1'b0;

    // Directed operations from the definition of each op and the special cases.
    issue(3'd0, 32'd7,         32'hFFFF_FFFD, 5'd5);
    issue(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
    issue(3'd2, 32'hFFFF_FFFF, 32'd2,         5'd8);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2,         5'd9);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2,         5'd10);
    issue(3'd5, 32'd100,       32'd7,         5'd11);
    issue(3'd7, 32'd100,       32'd7,         5'd12);
    issue(3'd4, 32'd5,         32'd0,         5'd13);
    issue(3'd6, 32'd5,         32'd0,         5'd14);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16);
    issue(3'd0, 32'd3,         32'd4,         5'd0);

    // Back-pressure: result must hold while i_ready is low, then write once.
    @(posedge i_clk); #1;
    i_ready = 1'b0;
    issue(3'd5, 32'd100, 32'd7, 5'd17);
    for (int k = 0; k < 5; k++) begin
      check("hold_data",  o_rd_data, 32'd14);
      check("hold_addr",  {27'b0, o_rd_addr}, 32'd17);
      check("hold_ready", {31'b0, o_ready}, 32'd0);
      check("hold_wren",  {31'b0, o_rd_wren}, 32'd0);
      @(negedge i_clk);
    end
    @(posedge i_clk); #1;
    wc = wren_count;
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    check("release_ready", {31'b0, o_ready}, 32'd1);
    check("release_valid", {31'b0, o_valid}, 32'd0);
    @(negedge i_clk);
    check("release_pulses", 32'(wren_count - wc), 32'd1);

    // Flush mid-calculation: no write-back may ever appear for it.
    @(posedge i_clk); #1;
    i_valid = 1'b1; i_op = 3'd4; i_rs1_data = 32'd1000; i_rs2_data = 32'd3; i_rd_addr = 5'd20;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    repeat (9) @(posedge i_clk);
    #1 i_flush = 1'b1;
    @(posedge i_clk); #1;
    i_flush = 1'b0;
    check("flush_ready", {31'b0, o_ready}, 32'd1);
    check("flush_valid", {31'b0, o_valid}, 32'd0);
    vcnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge i_clk);
      if (o_valid) vcnt++;
    end
    check("flush_no_valid", 32'(vcnt), 32'd0);
    issue(3'd5, 32'd9, 32'd3, 5'd21);

    // Flush with a request in IDLE: the request must not be accepted.
    @(posedge i_clk); #1;
    i_valid = 1'b1; i_flush = 1'b1; i_op = 3'd0; i_rs1_data = 32'd2; i_rs2_data = 32'd2;
    i_rd_addr = 5'd22;
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_flush = 1'b0;
    check("flush_idle_ready", {31'b0, o_ready}, 32'd1);

    // Random operations against the reference model.
    for (int k = 0; k < 40; k++) begin
      issue(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), 5'($urandom));
    end

    // Async reset in the middle of CALC takes effect without a clock edge.
    @(posedge i_clk); #1;
    i_valid = 1'b1; i_op = 3'd0; i_rs1_data = 32'd123; i_rs2_data = 32'd456; i_rd_addr = 5'd3;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    repeat (5) @(posedge i_clk);
    #3 i_reset = 1'b1;
    #1;
    check("arst_ready", {31'b0, o_ready}, 32'd1);
    check("arst_valid", {31'b0, o_valid}, 32'd0);
    check("arst_data",  o_rd_data, 32'd0);
    check("arst_addr",  {27'b0, o_rd_addr}, 32'd0);
    @(negedge i_clk);
    i_reset = 1'b0;
    issue(3'd7, 32'd17, 32'd5, 5'd4);

    repeat (5) @(posedge i_clk);
    check("scoreboard_empty", 32'(exp_data_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
